// File: rtl/dma_bus_arbiter.sv
// Round-robin arbiter handing the external memory bus from the CPU to DMA masters.
// Optional ARB_PREEMPT_EN forces release after MAX_HOLD grant cycles when others wait.
module dma_bus_arbiter #(
    parameter int NREQ     = 2,
    parameter int AW       = 16,
    parameter int SETTLE   = 1,
    parameter int MAX_HOLD = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    input  logic [NREQ*AW-1:0] dma_addr,
    input  logic [NREQ-1:0]   dma_cs,
    input  logic [AW-1:0]     cpu_addr,
    input  logic              cpu_cs,
    output logic              cpu_halt,
    input  logic              cpu_ba,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_cs,
    output logic              busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_SETTLE,
        S_GRANT,
        S_RELEASE
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            halt_q, halt_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   own_q, own_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            ba_q;
    logic [IW-1:0]   win;
    logic [IW-1:0]   nxt_own;
    logic            found;
    int              idx;

`ifdef ARB_PREEMPT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0]   hold_q, hold_d;
    logic            others;
    assign others = |(req & ~gnt_q);
`endif

    // first requester at or after the round-robin pointer
    always_comb begin
        win   = rr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_q) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign nxt_own = IW'((int'(own_q) + 1) % NREQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            halt_q  <= 1'b0;
            rr_q    <= '0;
            own_q   <= '0;
            cnt_q   <= '0;
            ba_q    <= 1'b0;
`ifdef ARB_PREEMPT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            halt_q  <= halt_d;
            rr_q    <= rr_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            ba_q    <= cpu_ba;
`ifdef ARB_PREEMPT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        halt_d  = halt_q;
        rr_d    = rr_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
`ifdef ARB_PREEMPT_EN
        hold_d  = hold_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_HALT;
                    halt_d  = 1'b1;
                end
            end
            S_HALT: begin
                if (!(|req)) begin
                    state_d = S_IDLE;
                    halt_d  = 1'b0;
                end else if (ba_q) begin
                    state_d = S_SETTLE;
                    cnt_d   = 3'(SETTLE);
                end
            end
            S_SETTLE: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (|req) begin
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    own_d      = win;
                    state_d    = S_GRANT;
`ifdef ARB_PREEMPT_EN
                    hold_d     = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                    halt_d  = 1'b0;
                end
            end
            S_GRANT: begin
                if (!req[own_q]) begin
                    gnt_d   = '0;
                    rr_d    = nxt_own;
                    state_d = S_RELEASE;
                end
`ifdef ARB_PREEMPT_EN
                else if (hold_q == HW'(MAX_HOLD - 1) && others) begin
                    gnt_d   = '0;
                    rr_d    = nxt_own;
                    state_d = S_RELEASE;
                end else if (hold_q != HW'(MAX_HOLD - 1)) begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
            S_RELEASE: begin
                if (|req) begin
                    state_d = S_SETTLE;
                    cnt_d   = 3'(SETTLE);
                end else begin
                    state_d = S_IDLE;
                    halt_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // CPU took the bus back without being released: drop grant, re-handshake
        if ((state_q == S_SETTLE || state_q == S_GRANT ||
             state_q == S_RELEASE) && !cpu_ba) begin
            gnt_d   = '0;
            state_d = S_HALT;
        end
    end

    assign gnt      = gnt_q;
    assign cpu_halt = halt_q;
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        mem_addr = cpu_addr;
        mem_cs   = cpu_cs;
        if (state_q == S_GRANT) begin
            mem_addr = dma_addr[int'(own_q)*AW +: AW];
            mem_cs   = dma_cs[own_q];
        end else if (halt_q) begin
            mem_cs = 1'b0;
        end
    end

endmodule
